// File: rtl/spram_be_bank.sv
// spram_be_bank
// Banked single-port RAM with per-byte write enables, a power-up/reset
// clear sequence and a credit-controlled read response path.
//
// Ports
//   clock_in    : clock, everything is on its rising edge
//   reset_in    : asynchronous active-low reset
//   req_valid   : request present
//   req_ready   : request accepted when req_valid && req_ready
//   req_write   : 1 = write, 0 = read
//   req_addr    : word address, low bits pick the bank, high bits the word
//   req_byteena : per-byte write enable (ignored on reads)
//   req_data    : write data
//   rsp_valid   : read data present
//   rsp_ready   : consumer takes read data
//   rsp_data    : read data, zero when nothing is valid
//   init_busy   : memory clear in progress
module spram_be_bank #(
  parameter int NUM_BANKS    = 4,
  parameter int NUM_WORDS    = 256,
  parameter int WIDTH        = 32,
  parameter int WIDTHAD      = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WIDTHAD-1:0]   req_addr,
  input  logic [WIDTH/8-1:0]   req_byteena,
  input  logic [WIDTH-1:0]     req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 init_busy
);

  localparam int NBYTES    = WIDTH / 8;
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WORD_BITS = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int DEPTH     = READ_LATENCY + 1;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [WORD_BITS-1:0]   init_idx;
  logic [CNT_W-1:0]       credit;

  logic [BANK_BITS-1:0]   bank_sel;
  logic [WORD_BITS-1:0]   word_sel;
  logic                   accept;
  logic                   rd_en;
  logic                   wr_en;
  logic                   init_we;

  logic [NUM_BANKS*WIDTH-1:0] bank_q_flat;
  logic [BANK_BITS-1:0]   sel_q;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [WIDTH-1:0]       pipe_data0;
  logic [WIDTH-1:0]       pipe_data;
  logic                   pipe_valid;

  logic [WIDTH-1:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   rsp_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address split: low bits interleave consecutive words across banks.
  generate
    if (NUM_BANKS > 1) begin : g_multi_bank
      assign bank_sel = req_addr[BANK_BITS-1:0];
      assign word_sel = req_addr[WIDTHAD-1:BANK_BITS];
    end else begin : g_single_bank
      assign bank_sel = '0;
      assign word_sel = req_addr[WORD_BITS-1:0];
    end
  endgenerate

  // State register
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave INIT after the last word index has been cleared
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_idx == WORD_BITS'(NUM_WORDS - 1)) begin
      state_nxt = ST_RUN;
    end
  end

  // Outputs of the FSM; ready depends only on registered state and credits
  always_comb begin
    init_busy = (state == ST_INIT);
    init_we   = (state == ST_INIT);
    req_ready = (state == ST_RUN) && (credit < CNT_W'(DEPTH));
  end

  assign accept = req_valid && req_ready;
  assign rd_en  = accept && !req_write;
  assign wr_en  = accept && req_write;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      init_idx <= '0;
    end else if (state == ST_INIT) begin
      init_idx <= init_idx + 1'b1;
    end
  end

  // One RAM per bank; the clear sequence writes the same index in all banks.
  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [WIDTH-1:0] mem [NUM_WORDS];
      logic [WIDTH-1:0] q;
      logic             hit;

      assign hit = (bank_sel == BANK_BITS'(b));

      always_ff @(posedge clock_in) begin
        if (init_we) begin
          mem[init_idx] <= '0;
        end else if (wr_en && hit) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (req_byteena[i]) begin
              mem[word_sel][8*i +: 8] <= req_data[8*i +: 8];
            end
          end
        end
        if (rd_en && hit) begin
          q <= mem[word_sel];
        end
      end

      assign bank_q_flat[b*WIDTH +: WIDTH] = q;
    end
  endgenerate

  // Read pipeline control: remembers which bank answers and when
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      sel_q    <= '0;
      vld_pipe <= '0;
    end else begin
      if (rd_en) begin
        sel_q <= bank_sel;
      end
      vld_pipe[0] <= rd_en;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign pipe_data0 = bank_q_flat[sel_q*WIDTH +: WIDTH];
  assign pipe_valid = vld_pipe[READ_LATENCY-1];

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] data_q;
      always_ff @(posedge clock_in) begin
        if (vld_pipe[0]) begin
          data_q <= pipe_data0;
        end
      end
      assign pipe_data = data_q;
    end else begin : g_lat1
      assign pipe_data = pipe_data0;
    end
  endgenerate

  // Response path: an empty FIFO lets pipeline data through directly, so a
  // read costs exactly READ_LATENCY cycles and credits turn over every cycle.
  assign fifo_empty = (fifo_cnt == '0);
  assign rsp_valid  = !fifo_empty || pipe_valid;
  assign rsp_pop    = rsp_valid && rsp_ready;
  assign fifo_pop   = !fifo_empty && rsp_ready;
  assign fifo_push  = pipe_valid && !(fifo_empty && rsp_ready);

  always_comb begin
    rsp_data = '0;
    if (!fifo_empty) begin
      rsp_data = fifo_mem[rd_ptr];
    end else if (pipe_valid) begin
      rsp_data = pipe_data;
    end
  end

  // FIFO storage and pointers; credits guarantee it never overflows
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr] <= pipe_data;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (fifo_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credits: reads in the RAM pipeline plus responses waiting in the FIFO
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      credit <= '0;
    end else begin
      case ({rd_en, rsp_pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_be_bank.sv
// tb_spram_be_bank
// Self-checking bench for spram_be_bank (4 banks x 256 words, 32 bits,
// read latency 2). A flat word-array model applies byte-enable writes at
// acceptance time and predicts read data; observed responses are collected
// in order and compared against the predictions.
module tb_spram_be_bank;

  localparam int AW  = 10;
  localparam int W   = 32;
  localparam int NW  = 256;
  localparam int LAT = 2;

  logic          clock_in;
  logic          reset_in;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [W/8-1:0] req_byteena;
  logic [W-1:0]  req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          init_busy;

  int checks;
  int failures;
  int cyc;
  int acc_cnt;

  logic [W-1:0] ref_mem [1 << AW];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] obs_q [$];
  int           obs_cyc [$];

  spram_be_bank #(
    .NUM_BANKS    (4),
    .NUM_WORDS    (NW),
    .WIDTH        (W),
    .WIDTHAD      (AW),
    .READ_LATENCY (LAT)
  ) dut (
    .clock_in    (clock_in),
    .reset_in    (reset_in),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_byteena (req_byteena),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .init_busy   (init_busy)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Called at a falling edge with inputs already set: records what the next
  // rising edge will accept or pop, then advances to the next falling edge.
  task automatic tick();
    if (req_valid && req_ready) begin
      acc_cnt++;
      if (req_write) begin
        for (int i = 0; i < W/8; i++) begin
          if (req_byteena[i]) ref_mem[req_addr][8*i +: 8] = req_data[8*i +: 8];
        end
      end else begin
        exp_q.push_back(ref_mem[req_addr]);
      end
    end
    if (rsp_valid && rsp_ready) begin
      obs_q.push_back(rsp_data);
      obs_cyc.push_back(cyc);
    end
    @(posedge clock_in);
    @(negedge clock_in);
    cyc++;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic clear_model();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [3:0] be,
                       input logic [W-1:0] d, output bit ok);
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = a;
    req_byteena = be;
    req_data    = d;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (req_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) tick();
    ok = (obs_q.size() == exp_q.size());
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_busy && n < 1000) begin
      @(posedge clock_in);
      @(negedge clock_in);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_byteena = '0; req_data = '0; rsp_ready = 1'b0;
    reset_in = 1'b1;
    #2 reset_in = 1'b0;
    #12;
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++;
    if (init_busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_init_busy: got %b expected 1", init_busy); end
    checks++;
    if (rsp_data !== '0) begin failures++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    clear_model();
    clear_queues();
    @(negedge clock_in);
    reset_in = 1'b1;
    wait_init(n);
    checks++;
    if (n !== NW) begin failures++; $display("[TB] FAIL init_cycles: got %0d expected %0d", n, NW); end
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_init: got %b expected 1", req_ready); end
  endtask

  task automatic test_init_zero();
    bit ok, all_ok;
    int bad, first_bad;
    all_ok = 1'b1;
    clear_queues();
    rsp_ready = 1'b1;
    for (int a = 0; a < (1 << AW); a++) begin
      issue(1'b0, AW'(a), 4'h0, '0, ok);
      all_ok &= ok;
    end
    drain(ok);
    all_ok &= ok;
    checks++;
    if (!all_ok || obs_q.size() != (1 << AW)) begin
      failures++;
      $display("[TB] FAIL init_read_count: got %0d responses expected %0d", obs_q.size(), 1 << AW);
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i] !== '0) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL init_read_zero: %0d nonzero words, first at addr %0d got %h expected 0",
               bad, first_bad, obs_q[first_bad]);
    end
  endtask

  task automatic test_byte_enable();
    bit ok, all_ok;
    all_ok = 1'b1;
    clear_queues();
    rsp_ready = 1'b1;
    issue(1'b1, AW'(5), 4'b1111, 32'hAABBCCDD, ok); all_ok &= ok;
    issue(1'b1, AW'(5), 4'b0101, 32'h11223344, ok); all_ok &= ok;
    issue(1'b0, AW'(5), 4'b0000, '0, ok);           all_ok &= ok;
    drain(ok); all_ok &= ok;
    checks++;
    if (!all_ok || obs_q.size() != 1) begin
      failures++;
      $display("[TB] FAIL byteena_count: got %0d responses expected 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== 32'hAA22CC44) begin
        failures++;
        $display("[TB] FAIL byteena_data: got %h expected AA22CC44", obs_q[0]);
      end
    end
  endtask

  task automatic test_interleave();
    bit ok, all_ok;
    int start, bad, nonzero;
    all_ok = 1'b1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      issue(1'b1, AW'(n), 4'hF, W'(n), ok); all_ok &= ok;
    end
    clear_queues();
    start = cyc;
    for (int n = 0; n < 8; n++) begin
      issue(1'b0, AW'(n), 4'h0, '0, ok); all_ok &= ok;
    end
    checks++;
    if (cyc - start != 8) begin
      failures++;
      $display("[TB] FAIL interleave_accept_rate: got %0d cycles expected 8", cyc - start);
    end
    drain(ok); all_ok &= ok;
    checks++;
    if (!all_ok || obs_q.size() != 8) begin
      failures++;
      $display("[TB] FAIL interleave_count: got %0d responses expected 8", obs_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (obs_q[i] !== W'(i) || obs_cyc[i] != obs_cyc[0] + i) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL interleave_order: %0d bad responses, last got %h at +%0d expected 7 at +7",
                 bad, obs_q[7], obs_cyc[7] - obs_cyc[0]);
      end
    end
    checks++;
    if (dut.g_bank[1].mem[0] !== 32'd1 || dut.g_bank[1].mem[1] !== 32'd5) begin
      failures++;
      $display("[TB] FAIL bank1_contents: got %h %h expected 1 5",
               dut.g_bank[1].mem[0], dut.g_bank[1].mem[1]);
    end
    nonzero = 0;
    for (int i = 2; i < NW; i++) if (dut.g_bank[1].mem[i] !== '0) nonzero++;
    checks++;
    if (nonzero != 0) begin
      failures++;
      $display("[TB] FAIL bank1_other_words: got %0d nonzero words expected 0", nonzero);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc0, base, unstable;
    logic [W-1:0] held;
    bit have_held;
    clear_queues();
    rsp_ready = 1'b0;
    base = $urandom_range(0, 5);
    acc0 = acc_cnt;
    unstable = 0;
    have_held = 1'b0;
    held = '0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = AW'(base + (acc_cnt - acc0));
      if (rsp_valid) begin
        if (have_held && rsp_data !== held) unstable++;
        held = rsp_data;
        have_held = 1'b1;
      end
      tick();
    end
    checks++;
    if (acc_cnt - acc0 != LAT + 1) begin
      failures++;
      $display("[TB] FAIL bp_accepted: got %0d expected %0d", acc_cnt - acc0, LAT + 1);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_ready_low: got %b expected 0", req_ready);
    end
    checks++;
    if (unstable != 0 || rsp_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_hold_stable: got %0d changes valid=%b expected 0 changes valid=1",
               unstable, rsp_valid);
    end
    drain(ok);
    checks++;
    if (!ok || obs_q.size() != LAT + 1) begin
      failures++;
      $display("[TB] FAIL bp_resp_count: got %0d expected %0d", obs_q.size(), LAT + 1);
    end else begin
      for (int i = 0; i < LAT + 1; i++) begin
        checks++;
        if (obs_q[i] !== W'(base + i)) begin
          failures++;
          $display("[TB] FAIL bp_resp_data[%0d]: got %h expected %h", i, obs_q[i], W'(base + i));
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int bad, unstable;
    logic prev_stall;
    logic [W-1:0] prev_data;
    clear_queues();
    unstable = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_stall && (rsp_valid !== 1'b1 || rsp_data !== prev_data)) unstable++;
      req_valid   = ($urandom % 4) != 0;
      req_write   = $urandom % 2;
      req_addr    = (($urandom % 3) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      req_byteena = 4'($urandom);
      req_data    = $urandom;
      rsp_ready   = ($urandom % 4) != 0;
      prev_stall  = rsp_valid && !rsp_ready;
      prev_data   = rsp_data;
      tick();
    end
    drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL random_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        if (bad == 0)
          $display("[TB] FAIL random_data[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL random_data_total: got %0d wrong responses expected 0", bad);
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("[TB] FAIL random_hold_stable: got %0d changes while stalled expected 0", unstable);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    clear_queues();
    rsp_ready = 1'b0;
    issue(1'b0, AW'(3), 4'h0, '0, ok);
    issue(1'b0, AW'(7), 4'h0, '0, ok);
    #2 reset_in = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (init_busy !== 1'b1) begin failures++; $display("[TB] FAIL midreset_init_busy: got %b expected 1", init_busy); end
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_req_ready: got %b expected 0", req_ready); end
    clear_model();
    clear_queues();
    @(negedge clock_in);
    reset_in = 1'b1;
    wait_init(n);
    checks++;
    if (n !== NW) begin failures++; $display("[TB] FAIL midreset_init_cycles: got %0d expected %0d", n, NW); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL midreset_stale: got %0d responses expected 0", obs_q.size());
    end
    issue(1'b0, AW'(3), 4'h0, '0, ok);
    drain(ok);
    checks++;
    if (!ok || obs_q.size() != 1 || obs_q[0] !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_read_cleared: got %0d responses first %h expected 1 response 0",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'hFFFFFFFF);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    acc_cnt = 0;
    test_reset();
    test_init_zero();
    test_byte_enable();
    test_interleave();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends on its own
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
